// File: rtl/uart_tx_rx.sv
// uart_tx_rx: 8N1 UART serialiser/deserialiser for the memory controller's
// UART register port. TX and RX are independent, so full duplex works.
//
// Ports:
//   clk, rst_n         system clock; asynchronous active-low reset
//   tx_en, tx_data     send request (sampled every cycle) and the byte to send
//   tx_busy            a frame is in flight
//   rx_en              receiver enable (level); low forces the receiver idle
//   rx_break           line held low for a whole frame, until it returns high
//   rx_valid, rx_data  one-cycle strobe and the last good received byte
//   uart_txd, uart_rxd serial pads, both idle high; uart_rxd is asynchronous
module uart_tx_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  input  logic       rx_en,
  output logic       rx_break,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          uart_txd_q, uart_txd_d;
  logic          tx_busy_q, tx_busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      uart_txd_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      uart_txd_q <= uart_txd_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // uart_txd is registered one state ahead: each transition loads the level
  // of the bit that the new state transmits.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + ONE;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    uart_txd_d = uart_txd_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_en) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          uart_txd_d = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          uart_txd_d = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            uart_txd_d = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            uart_txd_d = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        // Back to IDLE for one cycle; a held tx_en is accepted there.
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_busy_d  = 1'b0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign uart_txd = uart_txd_q;
  assign tx_busy  = tx_busy_q;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  // Synchroniser and edge-detect flops reset high (idle line) so that
  // leaving reset never looks like a start bit.
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // The edge history runs regardless of rx_en, so a line already low when
  // rx_en rises shows no edge.
  assign rx_fall = rxd_prev_q & ~rxd_sync_q;

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_break_q, rx_break_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_break_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_break_q <= rx_break_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + ONE;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_break_d = rx_break_q;
    if (!rx_en) begin
      rx_state_d = RX_IDLE;
      rx_cnt_d   = '0;
      rx_break_d = 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_d = '0;
          if (rx_fall) rx_state_d = RX_START;
        end
        RX_START: begin
          // Mid start bit; a high line here means the edge was a glitch.
          if (rx_cnt_q == HALF) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == LAST) begin
            rx_cnt_d = '0;
            if (rxd_sync_q) begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              // All-zero frame with low stop bit is a break; anything else
              // is a framing error and the byte is dropped.
              rx_break_d = (rx_shift_q == 8'h00);
              rx_state_d = RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          rx_cnt_d = '0;
          if (rxd_sync_q) begin
            rx_break_d = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_break = rx_break_q;

endmodule

// File: tb/tb_uart_tx_rx.sv
module tb_uart_tx_rx;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_en;
  logic       rx_break;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       uart_txd;
  logic       uart_rxd;

  int tests = 0;
  int fails = 0;
  int vtotal = 0;
  int snap;

  uart_tx_rx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_en(rx_en), .rx_break(rx_break), .rx_valid(rx_valid), .rx_data(rx_data),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );

  always #5 clk = ~clk;

  // Count rx_valid pulses, sampled away from the active edge.
  always @(negedge clk) if (rx_valid === 1'b1) vtotal <= vtotal + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Called one cycle after the accept edge: checks all 10*N cycles of a frame.
  task automatic check_tx_frame(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < N; c++) begin
        chk("tx_bit", 32'({tx_busy, uart_txd}), 32'({1'b1, f[b]}));
        tick();
      end
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uart_rxd = f[b];
      repeat (N) tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; tx_en = 1'b0; tx_data = 8'h00; rx_en = 1'b0; uart_rxd = 1'b1;
    repeat (3) tick();
    chk("rst_txd",      32'(uart_txd), 32'd1);
    chk("rst_busy",     32'(tx_busy),  32'd0);
    chk("rst_valid",    32'(rx_valid), 32'd0);
    chk("rst_break",    32'(rx_break), 32'd0);
    chk("rst_rx_data",  32'(rx_data),  32'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: single frame A5
    tx_en = 1'b1; tx_data = 8'hA5;
    tick();
    tx_en = 1'b0; tx_data = 8'h00;
    check_tx_frame(8'hA5);
    chk("t1_end", 32'({tx_busy, uart_txd}), 32'b01);
    repeat (5) tick();

    // 2: tx_en held: second frame starts right after one IDLE cycle
    tx_en = 1'b1; tx_data = 8'h3C;
    tick();
    check_tx_frame(8'h3C);
    chk("t2_boundary", 32'({tx_busy, uart_txd}), 32'b01);
    tick();
    tx_en = 1'b0;
    check_tx_frame(8'h3C);
    chk("t2_end", 32'({tx_busy, uart_txd}), 32'b01);
    repeat (20) tick();
    chk("t2_no_third", 32'({tx_busy, uart_txd}), 32'b01);

    // 3: receive 5A
    rx_en = 1'b1;
    repeat (4) tick();
    snap = vtotal;
    send_rx_frame(8'h5A, 1'b1);
    repeat (10) tick();
    chk("t3_valid_cnt", 32'(vtotal - snap), 32'd1);
    chk("t3_rx_data",   32'(rx_data),       32'h5A);
    repeat (30) tick();
    chk("t3_rx_hold",   32'(rx_data),       32'h5A);
    chk("t3_break",     32'(rx_break),      32'd0);

    // 4: 3-cycle glitch, then a good FF frame
    snap = vtotal;
    uart_rxd = 1'b0;
    repeat (3) tick();
    uart_rxd = 1'b1;
    repeat (30) tick();
    chk("t4_glitch_valid", 32'(vtotal - snap), 32'd0);
    send_rx_frame(8'hFF, 1'b1);
    repeat (10) tick();
    chk("t4_ff_valid", 32'(vtotal - snap), 32'd1);
    chk("t4_ff_data",  32'(rx_data),       32'hFF);

    // 5: break, then framing error
    snap = vtotal;
    uart_rxd = 1'b0;
    repeat (90) tick();
    chk("t5_break_set",  32'(rx_break), 32'd1);
    repeat (6) tick();
    chk("t5_break_hold", 32'(rx_break), 32'd1);
    uart_rxd = 1'b1;
    repeat (5) tick();
    chk("t5_break_clr",  32'(rx_break), 32'd0);
    repeat (10) tick();
    send_rx_frame(8'h01, 1'b0);
    repeat (2) tick();
    chk("t5_ferr_break", 32'(rx_break), 32'd0);
    uart_rxd = 1'b1;
    repeat (10) tick();
    chk("t5_valid_cnt", 32'(vtotal - snap), 32'd0);
    chk("t5_rx_data",   32'(rx_data),       32'hFF);

    // 5b: receiver still works after WAIT_HIGH
    snap = vtotal;
    send_rx_frame(8'hC3, 1'b1);
    repeat (10) tick();
    chk("t5b_valid", 32'(vtotal - snap), 32'd1);
    chk("t5b_data",  32'(rx_data),       32'hC3);

    // 6a: rx_en dropped mid-frame
    snap = vtotal;
    uart_rxd = 1'b0;             // start bit
    repeat (N) tick();
    for (int b = 0; b < 4; b++) begin uart_rxd = b[0]; repeat (N) tick(); end
    rx_en = 1'b0;
    for (int b = 0; b < 4; b++) begin uart_rxd = b[0]; repeat (N) tick(); end
    uart_rxd = 1'b1;
    chk("t6_break_off", 32'(rx_break), 32'd0);
    repeat (3 * N) tick();
    rx_en = 1'b1;
    repeat (20) tick();
    chk("t6_no_valid", 32'(vtotal - snap), 32'd0);
    chk("t6_rx_keep",  32'(rx_data),       32'hC3);

    // 6b: async reset in the middle of a TX data bit
    tx_en = 1'b1; tx_data = 8'h00;
    tick();
    tx_en = 1'b0;
    repeat (20) tick();
    chk("t6_tx_mid", 32'({tx_busy, uart_txd}), 32'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_txd",  32'(uart_txd), 32'd1);
    chk("t6_rst_busy", 32'(tx_busy),  32'd0);
    chk("t6_rst_data", 32'(rx_data),  32'h00);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6_post_rst", 32'({tx_busy, uart_txd}), 32'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
